bp_me_network_pkt_decode_cmd: RTL

BP_ME_NETWORK_PKT_DECODE_CMD -- requirements
Module: bp_me_network_pkt_decode_cmd

---
 rtl/bp_me_network_pkt_decode_cmd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bp_me_network_pkt_decode_cmd.sv
// Network packet to LCE command decoder.
// Reassembles a bp_cce_lce_cmd_s from a stream of LSB-first flits laid out as
// {payload, length, y_cord, x_cord}. The length field in the header flit says
// how many body flits follow; the finished command is held until consumed.
module bp_me_network_pkt_decode_cmd #(
  parameter int num_lce_p      = 4,
  parameter int num_cce_p      = 2,
  parameter int lce_assoc_p    = 8,
  parameter int paddr_width_p  = 22,
  parameter int max_num_flit_p = 5,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,

  // Command field widths, matching the command encoder's layout
  localparam int lce_id_w   = (num_lce_p   > 1) ? $clog2(num_lce_p)   : 1,
  localparam int cce_id_w   = (num_cce_p   > 1) ? $clog2(num_cce_p)   : 1,
  localparam int way_w      = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int cmd_type_w = 4,
  localparam int cmd_w      = lce_id_w + cce_id_w + cmd_type_w + way_w
                              + paddr_width_p + lce_id_w + way_w,

  // Packet framing
  localparam int len_w      = (max_num_flit_p > 1) ? $clog2(max_num_flit_p) : 1,
  localparam int hdr_w      = x_cord_width_p + y_cord_width_p + len_w,
  localparam int pkt_w      = hdr_w + cmd_w,
  localparam int width_lp   = (pkt_w + max_num_flit_p - 1) / max_num_flit_p,
  localparam int cmd_len_lp = (pkt_w + width_lp - 1) / width_lp - 1,
  localparam int buf_w      = (cmd_len_lp + 1) * width_lp
) (
  input  logic                clk_i,
  input  logic                reset_n_i,

  input  logic                link_v_i,
  input  logic [width_lp-1:0] link_data_i,
  output logic                link_ready_o,

  output logic [cmd_w-1:0]    cmd_o,
  output logic                cmd_v_o,
  input  logic                cmd_yumi_i,

  output logic                len_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e                             r_state;
  state_e                             w_state_nxt;

  logic [len_w-1:0]                   r_cnt;      // body flits still expected
  logic [len_w-1:0]                   r_idx;      // slot for the next body flit
  logic [cmd_len_lp:0][width_lp-1:0]  r_buf;      // assembly buffer, slot 0 = header
  logic                               r_len_err;

  logic                               w_accept;
  logic [len_w-1:0]                   w_len;
  logic                               w_len_ovf;
  logic [len_w-1:0]                   w_hdr_cnt;
  logic [buf_w-1:0]                   w_buf_flat;
  logic [buf_w-1:0]                   w_buf_shr;
  logic                               w_unused;

  assign w_accept  = link_v_i & link_ready_o;

  // Length field lives right above the coordinates in the header flit.
  // An oversized length is clamped so the buffer can never be overrun.
  assign w_len     = link_data_i[x_cord_width_p + y_cord_width_p +: len_w];
  assign w_len_ovf = (w_len > len_w'(cmd_len_lp));
  assign w_hdr_cnt = w_len_ovf ? len_w'(cmd_len_lp) : w_len;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state: header picks BODY or FULL, last body flit goes FULL, yumi frees
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_hdr_cnt == '0) ? S_FULL : S_BODY;
      S_BODY: if (w_accept && (r_cnt == len_w'(1))) w_state_nxt = S_FULL;
      S_FULL: if (cmd_yumi_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from the state register only
  always_comb begin
    link_ready_o = 1'b0;
    cmd_v_o      = 1'b0;
    case (r_state)
      S_IDLE:  link_ready_o = 1'b1;
      S_BODY:  link_ready_o = 1'b1;
      S_FULL:  cmd_v_o      = 1'b1;
      default: link_ready_o = 1'b0;
    endcase
  end

  // Datapath: header clears the buffer and loads the count, body flits fill slots
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_len_err <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        // Clearing first makes bits of short packets read back as zero
        r_buf    <= '0;
        r_buf[0] <= link_data_i;
        r_cnt    <= w_hdr_cnt;
        r_idx    <= len_w'(1);
        if (w_len_ovf) r_len_err <= 1'b1;
      end else if (r_state == S_BODY) begin
        for (int s = 1; s <= cmd_len_lp; s++) begin
          if (r_idx == len_w'(s)) r_buf[s] <= link_data_i;
        end
        r_idx <= r_idx + len_w'(1);
        r_cnt <= r_cnt - len_w'(1);
      end
    end
  end

  // Command sits just above the header in the reassembled packet
  assign w_buf_flat = r_buf;
  assign w_buf_shr  = w_buf_flat >> hdr_w;
  assign cmd_o      = w_buf_shr[cmd_w-1:0];
  assign len_err_o  = r_len_err;

  // Header and padding bits are carried in the buffer but never leave it
  assign w_unused   = ^w_buf_shr;

endmodule
